// File: rtl/fft_stage_sequencer_if.sv
// Operation handshake between the FFT stage sequencer and the butterfly/reorder datapath.
// L is the address width; it must equal $clog2(SAMPLES) of the attached sequencer.
interface fft_stage_sequencer_if #(
  parameter int L = 2
);
  logic         start;
  logic         busy;
  logic         done;
  logic         phase;
  logic [L-1:0] stage;
  logic         op_valid;
  logic         op_ack;
  logic [L-1:0] addr_a;
  logic [L-1:0] addr_b;
  logic [L-2:0] twiddle;

  modport master (
    input  start, op_ack,
    output busy, done, phase, stage, op_valid, addr_a, addr_b, twiddle
  );

  modport slave (
    output start, op_ack,
    input  busy, done, phase, stage, op_valid, addr_a, addr_b, twiddle
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT control sequencer: bit-reversal swap pass, then log2(SAMPLES)
// butterfly stages, one operation per handshake. Outputs are Moore-decoded.
module fft_stage_sequencer #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_stage_sequencer_if.master bus
);
  localparam int L    = $clog2(SAMPLES);
  localparam int KW   = L - 1;
  localparam int HALF = SAMPLES / 2;

  localparam logic [L-1:0]  I_LAST = L'(SAMPLES - 1);
  localparam logic [L-1:0]  S_LAST = L'(L - 1);
  localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

  if (SAMPLES < 4 || (SAMPLES & (SAMPLES - 1)) != 0 || WIDTH < 1) begin : g_param_check
    $error("fft_stage_sequencer: SAMPLES must be a power of two >= 4 and WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REORDER,
    S_BFLY,
    S_DONE
  } state_t;

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] res;
    for (int b = 0; b < L; b++) res[b] = v[L-1-b];
    return res;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [L-1:0]    r_i, w_i_nxt;
  logic [L-1:0]    r_s, w_s_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;

  logic            w_busy, w_done, w_phase, w_valid, w_adv;
  logic [L-1:0]    w_stage, w_a, w_b;
  logic [KW-1:0]   w_tw;

  logic [L-1:0]    w_rev, w_k_ext, w_h, w_pos, w_grp, w_base_a;
  logic [KW-1:0]   w_tw_calc;

  // Operand decode: k = grp*h + pos, group stride is 2h.
  assign w_rev     = bitrev(r_i);
  assign w_k_ext   = {1'b0, r_k};
  assign w_h       = L'(1) << r_s;
  assign w_pos     = w_k_ext & (w_h - L'(1));
  assign w_grp     = w_k_ext >> r_s;
  assign w_base_a  = (w_grp << (r_s + L'(1))) + w_pos;
  assign w_tw_calc = w_pos[KW-1:0] << (S_LAST - r_s);

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_s_nxt     = r_s;
    w_k_nxt     = r_k;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_phase     = 1'b0;
    w_stage     = '0;
    w_valid     = 1'b0;
    w_a         = '0;
    w_b         = '0;
    w_tw        = '0;
    w_adv       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_REORDER;
          w_i_nxt     = '0;
        end
      end
      S_REORDER: begin
        w_busy = 1'b1;
        if (r_i < w_rev) begin
          w_valid = 1'b1;
          w_a     = r_i;
          w_b     = w_rev;
          w_adv   = bus.op_ack;
        end else begin
          w_adv = 1'b1;
        end
        if (w_adv) begin
          if (r_i == I_LAST) begin
            w_state_nxt = S_BFLY;
            w_i_nxt     = '0;
            w_s_nxt     = '0;
            w_k_nxt     = '0;
          end else begin
            w_i_nxt = r_i + L'(1);
          end
        end
      end
      S_BFLY: begin
        w_busy  = 1'b1;
        w_phase = 1'b1;
        w_stage = r_s;
        w_valid = 1'b1;
        w_a     = w_base_a;
        w_b     = w_base_a + w_h;
        w_tw    = w_tw_calc;
        if (bus.op_ack) begin
          if (r_k == K_LAST) begin
            w_k_nxt = '0;
            if (r_s == S_LAST) begin
              w_state_nxt = S_DONE;
              w_s_nxt     = '0;
            end else begin
              w_s_nxt = r_s + L'(1);
            end
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_s     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_s     <= w_s_nxt;
      r_k     <= w_k_nxt;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.phase    = w_phase;
  assign bus.stage    = w_stage;
  assign bus.op_valid = w_valid;
  assign bus.addr_a   = w_a;
  assign bus.addr_b   = w_b;
  assign bus.twiddle  = w_tw;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at SAMPLES=4 and SAMPLES=8 with an
// expected-operation scoreboard built from an independent group/offset loop.
module tb_fft_stage_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start4, ack4, start8, ack8;

  fft_stage_sequencer_if #(.L(2)) if4 ();
  fft_stage_sequencer_if #(.L(3)) if8 ();

  assign if4.start  = start4;
  assign if4.op_ack = ack4;
  assign if8.start  = start8;
  assign if8.op_ack = ack8;

  fft_stage_sequencer #(.SAMPLES(4), .WIDTH(3)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
  fft_stage_sequencer #(.SAMPLES(8), .WIDTH(3)) u_dut8 (.clk(clk), .reset(reset), .bus(if8));

  typedef struct packed {
    logic       phase;
    logic [2:0] stage;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] tw;
  } op_t;

  op_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  n_fail = 0;

  logic       o_busy, o_done, o_phase, o_valid;
  logic [2:0] o_stage, o_a, o_b, o_tw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic snap(input int n);
    if (n == 4) begin
      o_busy  = if4.busy;    o_done = if4.done;  o_phase = if4.phase; o_valid = if4.op_valid;
      o_stage = {1'b0, if4.stage};
      o_a     = {1'b0, if4.addr_a};
      o_b     = {1'b0, if4.addr_b};
      o_tw    = {2'b00, if4.twiddle};
    end else begin
      o_busy  = if8.busy;    o_done = if8.done;  o_phase = if8.phase; o_valid = if8.op_valid;
      o_stage = if8.stage;
      o_a     = if8.addr_a;
      o_b     = if8.addr_b;
      o_tw    = {1'b0, if8.twiddle};
    end
  endtask

  function automatic logic [31:0] all_out();
    return {16'd0, o_busy, o_done, o_phase, o_valid, o_stage, o_a, o_b, o_tw};
  endfunction

  task automatic drive(input int n, input logic st, input logic ak);
    if (n == 4) begin start4 = st; ack4 = ak; end
    else        begin start8 = st; ack8 = ak; end
  endtask

  // Expected order: swap pairs by ascending i, then per stage groups of span 2h, offset j.
  task automatic push_expected(input int n);
    int  lg, r, h, span;
    op_t op;
    lg = (n == 4) ? 2 : 3;
    for (int i = 0; i < n; i++) begin
      r = 0;
      for (int b = 0; b < lg; b++) if (((i >> b) & 1) == 1) r = r | (1 << (lg - 1 - b));
      if (i < r) begin
        op.phase = 1'b0; op.stage = 3'd0; op.a = 3'(i); op.b = 3'(r); op.tw = 3'd0;
        exp_q.push_back(op);
      end
    end
    for (int s = 0; s < lg; s++) begin
      h    = 1 << s;
      span = 2 * h;
      for (int g = 0; g < n; g += span) begin
        for (int j = 0; j < h; j++) begin
          op.phase = 1'b1; op.stage = 3'(s); op.a = 3'(g + j); op.b = 3'(g + j + h);
          op.tw    = 3'(j * (n / span));
          exp_q.push_back(op);
        end
      end
    end
  endtask

  task automatic run(input int n, input int hold_from, input int hold_len,
                     input int sp1, input int sp2, input int exp_done, input int exp_busy);
    int   c, busy_cnt, reo_cnt, done_at;
    logic ak;
    op_t  got;
    c = 0; busy_cnt = 0; reo_cnt = 0; done_at = -1;
    exp_q.delete();
    push_expected(n);
    drive(n, 1'b1, 1'b1);
    while (done_at < 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
      ak = !(c >= hold_from && c < hold_from + hold_len);
      drive(n, (c == sp1 || c == sp2), ak);
      snap(n);
      if (o_busy) busy_cnt++;
      if (o_busy && !o_phase) reo_cnt++;
      if (o_valid) begin
        got = {o_phase, o_stage, o_a, o_b, o_tw};
        if (exp_q.size() == 0) check($sformatf("n%0d_c%0d_unexpected_op", n, c), exp_q.size(), 1);
        else begin
          check($sformatf("n%0d_c%0d_op", n, c), got, exp_q[0]);
          if (ak) void'(exp_q.pop_front());
        end
      end else if (o_busy) begin
        check($sformatf("n%0d_c%0d_idle_operands", n, c), {o_phase, o_stage, o_a, o_b, o_tw}, 0);
      end
      if (o_done) begin
        done_at = c;
        check($sformatf("n%0d_done_only", n), all_out(), 32'h4000);
      end
    end
    check($sformatf("n%0d_done_cycle", n), done_at, exp_done);
    check($sformatf("n%0d_busy_cycles", n), busy_cnt, exp_busy);
    check($sformatf("n%0d_reorder_cycles", n), reo_cnt, n);
    check($sformatf("n%0d_ops_left", n), exp_q.size(), 0);
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1;
      drive(n, 1'b0, 1'b1);
      snap(n);
      check($sformatf("n%0d_post_idle%0d", n, p), all_out(), 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(4, 1'b0, 1'b0);
    drive(8, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      snap(4); check($sformatf("rst4_%0d", c), all_out(), 0);
      snap(8); check($sformatf("rst8_%0d", c), all_out(), 0);
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      snap(4); check($sformatf("idle4_%0d", c), all_out(), 0);
      snap(8); check($sformatf("idle8_%0d", c), all_out(), 0);
    end

    run(4, 0, 0, -1, -1, 9, 8);
    run(8, 0, 0, -1, -1, 21, 20);
    run(4, 8, 3, -1, -1, 12, 11);

    // Abort during stage 0, k=1, then a clean transform.
    drive(4, 1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      drive(4, 1'b0, 1'b1);
    end
    snap(4);
    check("abort_point", {o_busy, o_phase, o_valid, o_stage, o_a, o_b}, {3'b111, 3'd0, 3'd2, 3'd3});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    snap(4);
    check("abort_idle", all_out(), 0);
    run(4, 0, 0, -1, -1, 9, 8);

    // Starts during BFLY (cycle 6) and DONE (cycle 9) must be ignored.
    run(4, 0, 0, 6, 9, 9, 8);
    run(4, 0, 0, -1, -1, 9, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control sequencer for the radix-2 decimation-in-time FFT datapath.
- After a start pulse, it first issues the bit-reversal swap pairs that reorder the sample memory.
- It then steps through the log2(SAMPLES) butterfly stages, issuing one (addr_a, addr_b, twiddle) butterfly per handshake.
- It drives the stage index consumed by the step-1 bit-reversal logic and the butterfly unit, and signals done when the transform is complete.

Parameters:
- SAMPLES, 4, FFT points; power of two, at least 4.
- WIDTH, 3, sample bit width; passed through for the datapath, not used internally.
- L (localparam), $clog2(SAMPLES), number of stages and address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a transform; sampled only in IDLE
- busy  output  1  high in REORDER and BFLY
- done  output  1  one-cycle pulse in DONE
- phase  output  1  0 = reorder swap, 1 = butterfly
- stage  output  L  current butterfly stage; 0 outside BFLY
- op_valid  output  1  addr_a/addr_b/twiddle hold a valid operation
- op_ack  input  1  datapath accepts the operation
- addr_a  output  L  first operand index
- addr_b  output  L  second operand index
- twiddle  output  L-1  twiddle index k into W_N^k

Behaviour:
- Synchronous, active-high reset on clk. Reset has priority over every other input, including mid-operation. Reset drives the FSM to IDLE and sets busy, done, phase, stage, op_valid, addr_a, addr_b, twiddle and all internal counters to 0.
- Outputs are Moore outputs, decoded from registered state and counters only. There is no combinational path from op_ack to any output.
- States: IDLE, REORDER, BFLY, DONE.
- IDLE:
  - All outputs are 0.
  - start=1 → REORDER next cycle, with scan counter i=0.
- REORDER:
  - busy=1, phase=0.
  - r = bit-reverse of i over L bits.
  - If i < r: op_valid=1, addr_a=i, addr_b=r, twiddle=0. Hold these values until op_ack=1, then i increments.
  - If i ≥ r: op_valid=0, addr_a=addr_b=twiddle=0, and i increments after one cycle.
  - When i advances past SAMPLES-1 → BFLY with s=0, k=0.
- BFLY:
  - busy=1, phase=1, stage=s, and k is the butterfly counter, 0..SAMPLES/2-1.
  - Operand and twiddle decode:
    - h = 1<<s
    - pos = k & (h-1)
    - grp = k >> s
    - addr_a = grp*2h + pos
    - addr_b = addr_a + h
    - twiddle = pos << (L-1-s)
  - op_valid=1 throughout. Counters and outputs stay stable until op_ack=1.
  - On ack:
    - if k < SAMPLES/2-1, then k++;
    - else k=0 and s++;
    - after the ack of the last butterfly of stage L-1 → DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, all other outputs 0.
  - Then → IDLE unconditionally.
- start is ignored outside IDLE.
  - A start asserted in DONE is ignored and must be re-asserted in IDLE.
  - A start held high continuously re-triggers the sequence after each return to IDLE.
- op_ack is ignored while op_valid=0 and in IDLE/DONE.
- Index arithmetic is modulo 2^L. Overflow cannot occur for legal SAMPLES.
- Latency with op_ack tied high:
  - start edge to first busy cycle = 1 cycle;
  - busy lasts SAMPLES + L*SAMPLES/2 cycles;
  - done follows busy immediately.

Test Plan:
- Reset and idle: hold reset 3 cycles, then start=0 for 5 cycles → all outputs 0 the whole time; busy and done never assert.
- SAMPLES=4, ack tied high, 1-cycle start:
  - REORDER lasts 4 cycles with op_valid only at i=1, giving (a=1, b=2).
  - BFLY then issues, in order:
    - stage 0: (0,1,tw0), (2,3,tw0)
    - stage 1: (0,2,tw0), (1,3,tw1)
  - done pulses exactly on cycle 9 after start, then IDLE.
- SAMPLES=8, ack tied high:
  - Swaps are (1,4) and (3,6) only.
  - Stage 2 pairs/twiddles are (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - busy lasts 8+12=20 cycles.
- Backpressure, SAMPLES=4: op_ack=0 for 3 cycles on the stage-1 k=1 butterfly → addr_a=1, addr_b=3, twiddle=1 and stage=1 are held stable all 3 cycles; DONE comes one cycle after the first ack.
- Reset mid-operation: assert reset during stage 0, k=1 → the next cycle shows IDLE with all outputs 0; a new start then produces the full sequence from REORDER i=0.
- Start in busy/DONE: pulse start during BFLY and again during DONE → ignored, exactly one done pulse; the next start in IDLE runs a full second transform.
